// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART (TXD/RXD/CON registers) with 16x-oversampled receiver
module uart_mmio #(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        rxd,
    output logic        txd
);
    localparam int DIV = (CLK_HZ / (BAUD * 16)) < 1 ? 1 : CLK_HZ / (BAUD * 16);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_TOP = CW'(DIV - 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

    logic [CW-1:0] tick_cnt;
    logic tick, sel_txd, sel_rxd, sel_con, rd_rxd, rd_con;
    logic tx_irq_en, rx_irq_en, tx_done, rx_ready, tx_busy, frame_err, overrun;
    logic [7:0] rx_data, tx_shift, rx_shift;
    logic [1:0] tx_state, rx_state;
    logic [3:0] tx_tcnt, rx_tcnt;
    logic [2:0] tx_bit, rx_bit;
    logic rx_s1, rx_s2, rx_armed;
    logic tx_end, rx_stop, rx_load, rx_ferr;
    logic [6:0] con;
    logic unused;

    assign unused = ^wdata[31:8];
    assign tick = tick_cnt == TICK_TOP;
    assign sel_txd = addr == BASE_ADDR;
    assign sel_rxd = addr == BASE_ADDR + 32'd4;
    assign sel_con = addr == BASE_ADDR + 32'd8;
    assign rd_rxd = rd & sel_rxd;
    assign rd_con = rd & sel_con;
    assign con = {overrun, frame_err, tx_busy, rx_ready, tx_done, rx_irq_en, tx_irq_en};
    assign rdata = !rd ? 32'd0 : sel_rxd ? {24'd0, rx_data} : sel_con ? {25'd0, con} : 32'd0;
    assign irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_ready);
    assign txd = tx_state == S_START ? 1'b0 : tx_state == S_DATA ? tx_shift[0] : 1'b1;
    assign tx_end = tick && tx_state == S_STOP && tx_tcnt == 4'd15;
    assign rx_stop = tick && rx_state == S_STOP && rx_tcnt == 4'd15;
    assign rx_load = rx_stop & rx_s2;
    assign rx_ferr = rx_stop & ~rx_s2;

    always_ff @(posedge clk or negedge reset)
        if (!reset) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + CW'(1);

    // hardware set terms are OR-ed in so they win over a same-cycle read clear
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            {tx_irq_en, rx_irq_en, tx_done, rx_ready, frame_err, overrun} <= '0;
            rx_data <= '0;
        end else begin
            if (wr && sel_con) {rx_irq_en, tx_irq_en} <= wdata[1:0];
            tx_done <= tx_end | (tx_done & ~rd_con);
            rx_ready <= rx_load | (rx_ready & ~rd_rxd);
            frame_err <= rx_ferr | (frame_err & ~rd_con);
            overrun <= (rx_load & rx_ready) | (overrun & ~rd_con);
            if (rx_load) rx_data <= rx_shift;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_busy <= 1'b0;
            tx_shift <= '0;
            tx_tcnt <= '0;
            tx_bit <= '0;
        end else if (tx_state == S_IDLE) begin
            if (tx_busy && tick) begin
                tx_state <= S_START;
                tx_tcnt <= '0;
            end else if (!tx_busy && wr && sel_txd) begin
                tx_shift <= wdata[7:0];
                tx_busy <= 1'b1;
            end
        end else if (tick) begin
            tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) begin
                if (tx_state == S_START) begin
                    tx_state <= S_DATA;
                    tx_bit <= '0;
                end else if (tx_state == S_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit <= tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state <= S_STOP;
                end else begin
                    tx_state <= S_IDLE;
                    tx_busy <= 1'b0;
                end
            end
        end

    // rx_armed blocks a new start until the line has been seen high after a frame
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_armed <= 1'b0;
            rx_state <= S_IDLE;
            rx_tcnt <= '0;
            rx_bit <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            if (rx_state == S_IDLE) begin
                if (rx_s2) rx_armed <= 1'b1;
                if (tick && rx_armed && !rx_s2) begin
                    rx_state <= S_START;
                    rx_tcnt <= '0;
                end
            end else if (tick) begin
                rx_tcnt <= rx_tcnt + 4'd1;
                if (rx_state == S_START && rx_tcnt == 4'd7) begin
                    rx_tcnt <= '0;
                    rx_bit <= '0;
                    rx_state <= rx_s2 ? S_IDLE : S_DATA;
                end else if (rx_tcnt == 4'd15) begin
                    if (rx_state == S_DATA) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                    end else begin
                        rx_state <= S_IDLE;
                        rx_armed <= 1'b0;
                    end
                end
            end
        end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio with a register-level reference model
module tb_uart_mmio;
    localparam logic [31:0] A_TXD = 32'h4000_0018, A_RXD = A_TXD + 32'd4, A_CON = A_TXD + 32'd8;

    logic clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0, rxd = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic irq, txd;

    always #5 clk = ~clk;

    uart_mmio #(.CLK_HZ(1_600_000), .BAUD(100_000), .BASE_ADDR(A_TXD)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq(irq), .rxd(rxd), .txd(txd)
    );

    int errors = 0, checks = 0, rst_epoch = 0;
    logic [31:0] rd_q[$];
    string rd_name[$];
    logic [7:0] tx_q[$];
    bit m_txie, m_rxie, m_done, m_rdy, m_busy, m_fe, m_ov;
    logic [7:0] m_rxd;

    always @(negedge reset) rst_epoch++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] con_model();
        return 32'(m_txie + 2 * m_rxie + 4 * m_done + 8 * m_rdy + 16 * m_busy + 32 * m_fe + 64 * m_ov);
    endfunction

    task automatic model_reset();
        {m_txie, m_rxie, m_done, m_rdy, m_busy, m_fe, m_ov} = '0;
        m_rxd = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, input string name);
        rd_q.push_back(a == A_RXD ? {24'd0, m_rxd} : a == A_CON ? con_model() : 32'd0);
        rd_name.push_back(name);
        @(posedge clk);
        #1 rd = 1'b1; addr = a;
        @(posedge clk);
        #1 rd = 1'b0; addr = '0;
        if (a == A_RXD) m_rdy = 0;
        if (a == A_CON) {m_done, m_fe, m_ov} = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 wr = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1 wr = 1'b0; addr = '0;
        if (a == A_CON) {m_rxie, m_txie} = d[1:0];
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (irq !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic tx_byte(input logic [7:0] b, input bit timed);
        int n;
        tx_q.push_back(b);
        bus_write(A_TXD, {24'd0, b});
        wait_irq(n);
        check("tx_done_irq", irq, 1);
        if (timed) check("tx_frame_clocks", n, 161);
        m_done = 1;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        bit pre;
        int rise;
        f = {stop, b, 1'b0};
        pre = (m_txie & m_done) | (m_rxie & m_rdy);
        rise = -1;
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            for (int j = 1; j <= 16; j++) begin
                @(posedge clk);
                #1 if (i == 9 && rise < 0 && irq === 1'b1) rise = j;
            end
        end
        rxd = 1'b1;
        if (stop) begin
            if (m_rdy) m_ov = 1;
            m_rxd = b;
            m_rdy = 1;
        end else m_fe = 1;
        if (stop && m_rxie && !pre) check("rx_irq_mid_stop", 32'(rise >= 6 && rise <= 13), 1);
        repeat (16) @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (rd) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", rdata);
            end else check(rd_name.pop_front(), rdata, rd_q.pop_front());
        end

    initial forever begin : tx_monitor
        logic [7:0] b;
        logic ok;
        int ep;
        @(negedge txd);
        ep = rst_epoch;
        repeat (8) @(negedge clk);
        ok = txd == 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            b[i] = txd;
        end
        repeat (16) @(negedge clk);
        ok = ok && txd == 1'b1;
        if (ep == rst_epoch) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got frame 0x%0h expected none", b);
            end else begin
                check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
                check("tx_framing", {31'd0, ok}, 1);
            end
        end
    end

    initial begin
        int n;
        logic [7:0] b;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_txd", txd, 1);
        check("reset_irq", irq, 0);
        check("rdata_idle", rdata, 0);
        bus_read(A_CON, "reset_con");
        bus_read(A_RXD, "reset_rxd");

        bus_write(A_CON, 1);
        tx_byte(8'hA5, 1);
        bus_read(A_CON, "con_tx_done");
        bus_read(A_CON, "con_after_clear");
        check("irq_cleared_tx", irq, 0);

        bus_write(A_CON, 2);
        send_rx(8'h3C, 1);
        check("rx_irq", irq, 1);
        bus_read(A_RXD, "rxd_3c");
        bus_read(A_CON, "con_after_rxd");
        check("irq_cleared_rx", irq, 0);

        send_rx(8'h11, 1);
        send_rx(8'h22, 1);
        bus_read(A_CON, "con_overrun");
        bus_read(A_RXD, "rxd_overwrite");
        bus_read(A_CON, "con_after_overrun");

        send_rx(8'h99, 0);
        bus_read(A_CON, "con_frame_err");
        bus_read(A_RXD, "rxd_unchanged");
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        bus_read(A_CON, "con_after_glitch");
        bus_read(A_CON + 32'd4, "unmapped_read");
        bus_read(A_TXD, "txd_reads_zero");
        bus_write(A_CON + 32'd4, 32'hFF);
        bus_write(A_CON + 32'd1, 32'h3);
        bus_read(A_CON, "con_unmapped_write");

        bus_write(A_CON, 1);
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            tx_byte(b, 0);
            bus_read(A_CON, "con_rand_tx");
        end

        bus_write(A_CON, 2);
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            send_rx(b, $urandom_range(0, 3) != 0);
            n = $urandom_range(0, 2);
            if (n != 1) bus_read(A_CON, "con_rand_rx");
            if (n != 0) bus_read(A_RXD, "rxd_rand_rx");
        end

        bus_write(A_CON, 1);
        tx_q.push_back(8'hF0);
        bus_write(A_TXD, 32'hF0);
        m_busy = 1;
        bus_write(A_TXD, 32'h55);
        bus_read(A_CON, "con_busy");
        wait_irq(n);
        check("tx_busy_done_irq", irq, 1);
        m_busy = 0;
        m_done = 1;
        bus_read(A_CON, "con_after_busy");
        repeat (200) @(posedge clk);

        bus_write(A_TXD, 32'h0F);
        repeat (50) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("reset_mid_txd", txd, 1);
        check("reset_mid_irq", irq, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        bus_read(A_CON, "con_after_reset");
        bus_read(A_RXD, "rxd_after_reset");
        repeat (200) @(posedge clk);
        #1;
        check("tx_queue_drained", tx_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
